// File: rtl/red_89_pkg.sv
// Shared constants and state encoding for the 89-bit field reduction path.
// p = 2^89 - C_89, so 2^89 is congruent to C_89 (mod p).
package red_89_pkg;
    localparam int DATA_SIZE = 89;
    localparam int IN_W      = DATA_SIZE + 2;

    localparam logic [88:0] P_89 = 89'h19f393cffffffffffffffff;
    localparam logic [88:0] C_89 = 89'h60c6c30000000000000001;
    localparam logic [88:0] Q_88 = {1'b1, 88'd0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/red_89_lut.sv
// Correction LUT: corr_o = (m_i * 2^88) mod p, every entry fully reduced below p.
module red_89_lut
    import red_89_pkg::*;
(
    input  logic [2:0]  m_i,
    output logic [88:0] corr_o
);
    // Written in terms of 2^88 and C_89 (2*2^88 == C_89 mod p)
    localparam logic [88:0] K3 = Q_88 + C_89;
    localparam logic [88:0] K4 = C_89 + C_89;
    localparam logic [88:0] K5 = C_89 + C_89 + C_89 - Q_88;
    localparam logic [88:0] K6 = C_89 + C_89 + C_89;
    localparam logic [88:0] K7 = C_89 + C_89 + C_89 + C_89 - Q_88;

    always_comb begin
        corr_o = '0;
        case (m_i)
            3'd0: corr_o = '0;
            3'd1: corr_o = Q_88;
            3'd2: corr_o = C_89;
            3'd3: corr_o = K3;
            3'd4: corr_o = K4;
            3'd5: corr_o = K5;
            3'd6: corr_o = K6;
            3'd7: corr_o = K7;
            default: corr_o = '0;
        endcase
    end
endmodule

// File: rtl/red_89_fold_ctrl.sv
// Sequencer reducing a 91-bit value mod p: LUT folds until below 2^89, then one conditional subtract.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high; out_valid holds until taken.
module red_89_fold_ctrl
    import red_89_pkg::*;
#(
    parameter int MAX_FOLDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [90:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [88:0]   out_data,
    output logic          out_err,
    output logic [2:0]    out_folds
);
    localparam logic [2:0] MAX_F = 3'(MAX_FOLDS);

    state_e      state_q, state_d;
    logic [90:0] acc_q, acc_d;
    logic [2:0]  fold_cnt_q, fold_cnt_d;
    logic        err_q, err_d;
    logic [88:0] out_data_q, out_data_d;

    logic [88:0] corr;
    logic [89:0] fold_sum;
    logic        acc_ge_p;
    logic [88:0] acc_minus_p;

    red_89_lut u_lut (
        .m_i    (acc_q[90:88]),
        .corr_o (corr)
    );

    // Fold result is below 2^88 + p < 2^90
    assign fold_sum    = {2'b00, acc_q[87:0]} + {1'b0, corr};
    assign acc_ge_p    = (acc_q >= {2'b00, P_89});
    assign acc_minus_p = acc_q[88:0] - P_89;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            fold_cnt_q <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fold_cnt_q <= fold_cnt_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        fold_cnt_d = fold_cnt_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d      = in_data;
                    fold_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = FOLD;
                end
            end
            FOLD: begin
                if (acc_q[90:89] != 2'b00) begin
                    if (fold_cnt_q < MAX_F) begin
                        acc_d      = {1'b0, fold_sum};
                        fold_cnt_d = fold_cnt_q + 3'd1;
                    end else begin
                        err_d      = 1'b1;
                        out_data_d = '0;
                        state_d    = DONE;
                    end
                end else begin
                    state_d = SUB;
                end
            end
            SUB: begin
                // acc < 2^89 < 2p here, so a single subtract suffices
                out_data_d = acc_ge_p ? acc_minus_p : acc_q[88:0];
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = out_data_q;
        out_err   = err_q;
        out_folds = fold_cnt_q;
    end
endmodule
